// File: rtl/space_invaders_pkg.sv
// Shared screen, formation geometry and scoring definitions for the
// alien collision stage and the laser block.
package space_invaders_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam logic [9:0] PARK_X = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] PARK_Y = 10'(SCREEN_HEIGHT - 1);

  localparam int ROWS      = 5;
  localparam int COLS      = 8;
  localparam int ALIEN_W   = 40;
  localparam int ALIEN_H   = 20;
  localparam int H_SPACING = 60;
  localparam int V_SPACING = 40;

  localparam int POINTS_TOP = 30;
  localparam int POINTS_MID = 20;
  localparam int POINTS_LOW = 10;

  localparam int EXPLODE_FRAMES = 8;

  localparam int NUM_ALIENS = ROWS * COLS;
  localparam int ROW_W      = $clog2(ROWS);
  localparam int COL_W      = $clog2(COLS);
  localparam int IDX_W      = $clog2(NUM_ALIENS);
  localparam int EXP_W      = $clog2(EXPLODE_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } hit_state_e;

  function automatic logic [15:0] row_points(
    input logic [ROW_W-1:0] row
  );
    if (row == '0)
      return 16'(POINTS_TOP);
    else if (row < ROW_W'(3))
      return 16'(POINTS_MID);
    else
      return 16'(POINTS_LOW);
  endfunction

endpackage

// File: rtl/alien_hit_detector_if.sv
// Frame-tick, laser/formation inputs and hit/score/explosion
// outputs of the alien collision stage.
interface alien_hit_detector_if;
  import space_invaders_pkg::*;

  logic                  enable;
  logic                  newWave;
  logic [9:0]            xLaser;
  logic [9:0]            yLaser;
  logic [9:0]            xFormation;
  logic [9:0]            yFormation;
  logic                  killingAlien;
  logic [NUM_ALIENS-1:0] aliveMask;
  logic [5:0]            aliensLeft;
  logic [15:0]           score;
  logic                  waveCleared;
  logic                  explodeActive;
  logic [9:0]            explodeX;
  logic [9:0]            explodeY;
  logic                  busy;

  modport master (
    output enable, newWave,
    output xLaser, yLaser,
    output xFormation, yFormation,
    input  killingAlien, aliveMask,
    input  aliensLeft, score,
    input  waveCleared, explodeActive,
    input  explodeX, explodeY, busy
  );

  modport slave (
    input  enable, newWave,
    input  xLaser, yLaser,
    input  xFormation, yFormation,
    output killingAlien, aliveMask,
    output aliensLeft, score,
    output waveCleared, explodeActive,
    output explodeX, explodeY, busy
  );

endinterface

// File: rtl/alien_hit_detector_explosion_timer.sv
// Holds the explosion marker visible for a fixed number of
// frame ticks after each hit.
module explosion_timer (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  input  logic clear,
  output logic active
);
  import space_invaders_pkg::*;

  logic [EXP_W-1:0] cnt_q;
  logic [EXP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (load)
      cnt_d = EXP_W'(EXPLODE_FRAMES);
    else if (tick && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/alien_hit_detector.sv
// Collision stage: scans the alive formation once per frame tick
// against the latched laser and retires at most one alien.
module alien_hit_detector (
  input  logic                 clk,
  input  logic                 reset,
  alien_hit_detector_if.slave  bus
);
  import space_invaders_pkg::*;

  hit_state_e            state_q, state_d;
  logic [IDX_W-1:0]      k_q, k_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [10:0]           x0_q, x0_d;
  logic [10:0]           y0_q, y0_d;
  logic [9:0]            xl_q, xl_d;
  logic [9:0]            yl_q, yl_d;
  logic [9:0]            xf_q, xf_d;
  logic [NUM_ALIENS-1:0] alive_q, alive_d;
  logic [5:0]            left_q, left_d;
  logic [15:0]           score_q, score_d;
  logic [9:0]            ex_x_q, ex_x_d;
  logic [9:0]            ex_y_q, ex_y_d;
  logic                  kill_q, kill_d;
  logic                  clear_q, clear_d;

  logic        hit_load;
  logic        parked;
  logic        last_cell;
  logic        in_x, in_y;
  logic        on_screen;
  logic        hit;
  logic [10:0] xl_w, yl_w;
  logic [10:0] x_hi, y_hi;
  logic [16:0] score_sum;

  assign parked = (bus.xLaser == PARK_X)
               && (bus.yLaser == PARK_Y);

  assign xl_w = {1'b0, xl_q};
  assign yl_w = {1'b0, yl_q};
  assign x_hi = x0_q + 11'(ALIEN_W);
  assign y_hi = y0_q + 11'(ALIEN_H);

  // Low edge inclusive, high edge exclusive.
  assign in_x = (xl_w >= x0_q) && (xl_w < x_hi);
  assign in_y = (yl_w >= y0_q) && (yl_w < y_hi);
  assign on_screen = !x0_q[10] && !y0_q[10];

  assign hit = (state_q == SCAN)
            && alive_q[k_q]
            && in_x && in_y && on_screen;

  assign last_cell = (k_q == IDX_W'(NUM_ALIENS - 1));

  assign score_sum = {1'b0, score_q}
                   + {1'b0, row_points(row_q)};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    row_d    = row_q;
    col_d    = col_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    xl_d     = xl_q;
    yl_d     = yl_q;
    xf_d     = xf_q;
    alive_d  = alive_q;
    left_d   = left_q;
    score_d  = score_q;
    ex_x_d   = ex_x_q;
    ex_y_d   = ex_y_q;
    kill_d   = 1'b0;
    clear_d  = 1'b0;
    hit_load = 1'b0;

    if (bus.newWave) begin
      alive_d = '1;
      left_d  = 6'(NUM_ALIENS);
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.enable && !parked) begin
            xl_d    = bus.xLaser;
            yl_d    = bus.yLaser;
            xf_d    = bus.xFormation;
            x0_d    = {1'b0, bus.xFormation};
            y0_d    = {1'b0, bus.yFormation};
            k_d     = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            kill_d       = 1'b1;
            hit_load     = 1'b1;
            alive_d[k_q] = 1'b0;
            left_d       = left_q - 6'd1;
            clear_d      = (left_q == 6'd1);
            score_d      = score_sum[16] ? 16'hFFFF
                                         : score_sum[15:0];
            ex_x_d       = x0_q[9:0];
            ex_y_d       = y0_q[9:0];
            state_d      = DONE;
          end else if (last_cell) begin
            // A full miss also retires through DONE.
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
            if (col_q == COL_W'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
              x0_d  = {1'b0, xf_q};
              y0_d  = y0_q + 11'(V_SPACING);
            end else begin
              col_d = col_q + 1'b1;
              x0_d  = x0_q + 11'(H_SPACING);
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
      xf_q    <= '0;
      alive_q <= '1;
      left_q  <= 6'(NUM_ALIENS);
      score_q <= '0;
      ex_x_q  <= '0;
      ex_y_q  <= '0;
      kill_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      xf_q    <= xf_d;
      alive_q <= alive_d;
      left_q  <= left_d;
      score_q <= score_d;
      ex_x_q  <= ex_x_d;
      ex_y_q  <= ex_y_d;
      kill_q  <= kill_d;
      clear_q <= clear_d;
    end
  end

  explosion_timer u_explosion_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (hit_load),
    .tick   (bus.enable),
    .clear  (bus.newWave),
    .active (bus.explodeActive)
  );

  assign bus.killingAlien = kill_q;
  assign bus.aliveMask    = alive_q;
  assign bus.aliensLeft   = left_q;
  assign bus.score        = score_q;
  assign bus.waveCleared  = clear_q;
  assign bus.explodeX     = ex_x_q;
  assign bus.explodeY     = ex_y_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed bench for alien_hit_detector with formation at (100,50).
`timescale 1ns/1ps
module tb_alien_hit_detector;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  logic [39:0] exp_mask;
  int   exp_score;

  alien_hit_detector_if bus();

  alien_hit_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pts(input int r);
    if (r == 0) return 30;
    if (r < 3) return 20;
    return 10;
  endfunction

  // Fire one frame; report the cycle offsets from the enable cycle T.
  task automatic run_frame(
    input  int x,
    input  int y,
    output int hit_at,
    output int drop_at,
    output int pulses,
    output int clr_at
  );
    bus.xLaser = 10'(x);
    bus.yLaser = 10'(y);
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    hit_at  = -1;
    drop_at = -1;
    pulses  = 0;
    clr_at  = -1;
    for (int n = 1; n <= 60; n++) begin
      if (bus.killingAlien === 1'b1) begin
        pulses++;
        if (hit_at < 0) hit_at = n;
      end
      if (bus.waveCleared === 1'b1 && clr_at < 0) clr_at = n;
      if (bus.busy === 1'b0) begin
        drop_at = n;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.aliveMask !== 40'hFF_FFFF_FFFF) begin $display("FAIL rst_mask got %h want all ones", bus.aliveMask); fails++; end
    checks++; if (bus.aliensLeft !== 6'd40) begin $display("FAIL rst_left got %0d want 40", bus.aliensLeft); fails++; end
    checks++; if (bus.score !== 16'd0) begin $display("FAIL rst_score got %0d want 0", bus.score); fails++; end
    checks++; if (bus.killingAlien !== 1'b0 || bus.waveCleared !== 1'b0) begin $display("FAIL rst_pulses got %b%b want 00", bus.killingAlien, bus.waveCleared); fails++; end
    checks++; if (bus.explodeActive !== 1'b0 || bus.busy !== 1'b0) begin $display("FAIL rst_flags got %b%b want 00", bus.explodeActive, bus.busy); fails++; end
    checks++; if (bus.explodeX !== 10'd0 || bus.explodeY !== 10'd0) begin $display("FAIL rst_expl got %0d,%0d want 0,0", bus.explodeX, bus.explodeY); fails++; end
  endtask

  task automatic test_first_hit();
    int h, d, p, c;
    run_frame(120, 60, h, d, p, c);
    exp_mask[0] = 1'b0;
    exp_score   = 30;
    checks++; if (h !== 2 || p !== 1) begin $display("FAIL first_hit got at %0d x%0d want at 2 x1", h, p); fails++; end
    checks++; if (d !== 3) begin $display("FAIL first_busy got %0d want 3", d); fails++; end
    checks++; if (bus.aliveMask !== exp_mask) begin $display("FAIL first_mask got %h want %h", bus.aliveMask, exp_mask); fails++; end
    checks++; if (bus.aliensLeft !== 6'd39) begin $display("FAIL first_left got %0d want 39", bus.aliensLeft); fails++; end
    checks++; if (bus.score !== 16'd30) begin $display("FAIL first_score got %0d want 30", bus.score); fails++; end
    checks++; if (bus.explodeX !== 10'd100 || bus.explodeY !== 10'd50) begin $display("FAIL first_expl got %0d,%0d want 100,50", bus.explodeX, bus.explodeY); fails++; end
    checks++; if (bus.explodeActive !== 1'b1) begin $display("FAIL first_active got %b want 1", bus.explodeActive); fails++; end
  endtask

  task automatic test_edges();
    int h, d, p, c;
    int xs[4] = '{145, 200, 170, 139};
    int ys[4] = '{60, 60, 70, 69};
    for (int i = 0; i < 4; i++) begin
      run_frame(xs[i], ys[i], h, d, p, c);
      checks++; if (p !== 0 || d !== 42) begin $display("FAIL edge_miss%0d got pulses %0d drop %0d want 0 42", i, p, d); fails++; end
    end
    run_frame(160, 50, h, d, p, c);
    exp_mask[1] = 1'b0;
    exp_score  += 30;
    checks++; if (h !== 3 || p !== 1) begin $display("FAIL edge_low got at %0d x%0d want at 3 x1", h, p); fails++; end
    checks++; if (bus.explodeX !== 10'd160 || bus.explodeY !== 10'd50) begin $display("FAIL edge_expl got %0d,%0d want 160,50", bus.explodeX, bus.explodeY); fails++; end
  endtask

  task automatic test_row_cell();
    int h, d, p, c;
    run_frame(230, 95, h, d, p, c);
    exp_mask[10] = 1'b0;
    exp_score   += 20;
    checks++; if (h !== 12 || p !== 1) begin $display("FAIL cell10 got at %0d x%0d want at 12 x1", h, p); fails++; end
    checks++; if (bus.score !== 16'(exp_score)) begin $display("FAIL cell10_score got %0d want %0d", bus.score, exp_score); fails++; end
    checks++; if (bus.explodeX !== 10'd220 || bus.explodeY !== 10'd90) begin $display("FAIL cell10_expl got %0d,%0d want 220,90", bus.explodeX, bus.explodeY); fails++; end
    run_frame(230, 95, h, d, p, c);
    checks++; if (p !== 0 || d !== 42) begin $display("FAIL cell10_dead got pulses %0d drop %0d want 0 42", p, d); fails++; end
  endtask

  // Explosion counter is 7 here: the dead-alien frame consumed one tick.
  task automatic test_parked();
    for (int i = 0; i < 7; i++) begin
      bus.xLaser = 10'd639;
      bus.yLaser = 10'd479;
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.killingAlien !== 1'b0) begin $display("FAIL parked_busy%0d got %b%b want 00", i, bus.busy, bus.killingAlien); fails++; end
      if (i == 5) begin
        checks++; if (bus.explodeActive !== 1'b1) begin $display("FAIL expl_hold got %b want 1", bus.explodeActive); fails++; end
      end
      step();
    end
    checks++; if (bus.explodeActive !== 1'b0) begin $display("FAIL expl_drop got %b want 0", bus.explodeActive); fails++; end
    checks++; if (bus.aliveMask !== exp_mask || bus.score !== 16'(exp_score)) begin $display("FAIL parked_state got %h %0d want %h %0d", bus.aliveMask, bus.score, exp_mask, exp_score); fails++; end
  endtask

  task automatic test_wave_clear();
    int h, d, p, c, r, col;
    for (int k = 0; k < 40; k++) begin
      if (exp_mask[k]) begin
        r   = k / 8;
        col = k % 8;
        run_frame(110 + col * 60, 55 + r * 40, h, d, p, c);
        exp_mask[k] = 1'b0;
        exp_score  += pts(r);
        checks++; if (h !== 2 + k || p !== 1) begin $display("FAIL sweep_k%0d got at %0d x%0d want at %0d x1", k, h, p, 2 + k); fails++; end
        checks++; if (c !== ((exp_mask == 0) ? h : -1)) begin $display("FAIL sweep_clr%0d got %0d want %0d", k, c, (exp_mask == 0) ? h : -1); fails++; end
      end
    end
    checks++; if (bus.aliensLeft !== 6'd0 || bus.aliveMask !== 40'd0) begin $display("FAIL cleared got %0d %h want 0 0", bus.aliensLeft, bus.aliveMask); fails++; end
    checks++; if (bus.score !== 16'd720) begin $display("FAIL cleared_score got %0d want 720", bus.score); fails++; end
    bus.newWave = 1'b1;
    step();
    bus.newWave = 1'b0;
    exp_mask = '1;
    checks++; if (bus.aliveMask !== exp_mask || bus.aliensLeft !== 6'd40) begin $display("FAIL newwave got %h %0d want all ones 40", bus.aliveMask, bus.aliensLeft); fails++; end
    checks++; if (bus.score !== 16'd720) begin $display("FAIL newwave_score got %0d want 720", bus.score); fails++; end
  endtask

  task automatic test_newwave_priority();
    bus.xLaser = 10'd120;
    bus.yLaser = 10'd60;
    bus.enable = 1'b1;
    step();
    bus.enable  = 1'b0;
    bus.newWave = 1'b1;
    step();
    bus.newWave = 1'b0;
    checks++; if (bus.killingAlien !== 1'b0 || bus.busy !== 1'b0) begin $display("FAIL nw_hit got kill %b busy %b want 0 0", bus.killingAlien, bus.busy); fails++; end
    checks++; if (bus.aliveMask !== exp_mask || bus.score !== 16'd720) begin $display("FAIL nw_hit_state got %h %0d want %h 720", bus.aliveMask, bus.score, exp_mask); fails++; end
    bus.enable  = 1'b1;
    bus.newWave = 1'b1;
    step();
    bus.enable  = 1'b0;
    bus.newWave = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin $display("FAIL nw_enable got busy %b want 0", bus.busy); fails++; end
  endtask

  task automatic test_async_reset();
    int h, d, p, c;
    run_frame(120, 60, h, d, p, c);
    checks++; if (h !== 2 || bus.score !== 16'd750) begin $display("FAIL pre_rst got at %0d score %0d want 2 750", h, bus.score); fails++; end
    bus.xLaser = 10'd530;
    bus.yLaser = 10'd215;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.busy !== 1'b1 || bus.explodeActive !== 1'b1) begin $display("FAIL mid_scan got busy %b expl %b want 1 1", bus.busy, bus.explodeActive); fails++; end
    #2 reset = 1'b1;
    #1;
    test_reset();
    #1 reset = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.score !== 16'd0) begin $display("FAIL post_rst got busy %b score %0d want 0 0", bus.busy, bus.score); fails++; end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    exp_mask  = '1;
    exp_score = 0;
    reset = 1'b1;
    bus.enable     = 1'b0;
    bus.newWave    = 1'b0;
    bus.xLaser     = 10'd0;
    bus.yLaser     = 10'd0;
    bus.xFormation = 10'd100;
    bus.yFormation = 10'd50;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_first_hit();
    test_edges();
    test_row_cell();
    test_parked();
    test_wave_clear();
    test_newwave_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
